pool_window_feeder: RTL and testbench

- Producer end of the max-pool element stream. Walks a square feature map held in a 1-cycle-latency read memory and emits each element×element pooling window as a serial signed stream on pool_in/pool_en. This is the exact stream the max-pool unit consumes.
- Captures every per-window result (pool_out on pool_done) and writes it into a result memory in window raster order.
- Sequenced by a start/done handshake from the layer controller.

---
 rtl/pool_window_feeder.sv | 155 +++++++++++++++
 tb/tb_pool_window_feeder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_feeder.sv
// Walks a square feature map window by window, streams each window to the max-pool unit,
// and stores the per-window maxima in raster order. Optional stall input: `define POOL_STALL_EN.
module pool_window_feeder #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 10,
  parameter int RES_AW = 8,
  parameter int DIM_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  map_dim,
  input  logic [3:0]        element,
`ifdef POOL_STALL_EN
  input  logic              stall,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pool_rst,
  output logic              pool_en,
  output logic [DATA_W-1:0] pool_in,
  input  logic              pool_done,
  input  logic [DATA_W-1:0] pool_out,
  output logic              res_we,
  output logic [RES_AW-1:0] res_addr,
  output logic [DATA_W-1:0] res_data
);

  localparam int CNT_W = 2 * DIM_W;
  localparam int SUM_W = DIM_W + 2;
  localparam int AF_W  = 2 * DIM_W + 2;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CLR, FEED, FLUSH, DRAIN, FIN} state_t;

  state_t            state, state_n;
  logic [DIM_W-1:0]  dim_q;
  logic [3:0]        elem_q;
  logic [3:0]        kx, ky;
  logic [DIM_W-1:0]  wx, wy;
  logic [CNT_W-1:0]  win_cnt, cap_cnt;
  logic              rd_q, flush_q, res_we_q;
  logic [DATA_W-1:0] res_data_q;
  logic [RES_AW-1:0] res_addr_q;

  logic              stall_w;
  logic              step, last_kx, last_ky, wx_fit, wy_fit, pass_end, zero_win, accept;
  logic [AF_W-1:0]   addr_full;

`ifdef POOL_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign step     = (state == FEED) && !stall_w;
  assign last_kx  = (kx == elem_q - 4'd1);
  assign last_ky  = (ky == elem_q - 4'd1);
  // A further window column/row exists only if it still fits entirely inside the map.
  assign wx_fit   = (SUM_W'(wx) + SUM_W'(elem_q) + SUM_W'(elem_q)) <= SUM_W'(dim_q);
  assign wy_fit   = (SUM_W'(wy) + SUM_W'(elem_q) + SUM_W'(elem_q)) <= SUM_W'(dim_q);
  assign pass_end = step && last_kx && last_ky && !wx_fit && !wy_fit;
  assign zero_win = (elem_q == 4'd0) || (SUM_W'(elem_q) > SUM_W'(dim_q));
  assign accept   = pool_done && ((state == FEED) || (state == FLUSH) || (state == DRAIN));

  assign addr_full = (AF_W'(wy) + AF_W'(ky)) * AF_W'(dim_q) + AF_W'(wx) + AF_W'(kx);

  always_comb begin
    state_n  = state;
    busy     = (state != IDLE);
    done     = (state == FIN);
    pool_rst = (state == CLR);
    mem_rd   = step;
    mem_addr = step ? ADDR_W'(addr_full) : '0;
    case (state)
      IDLE:  if (start) state_n = CLR;
      CLR:   state_n = zero_win ? FIN : FEED;
      FEED:  if (pass_end) state_n = FLUSH;
      FLUSH: if (!stall_w) state_n = DRAIN;
      DRAIN: if (cap_cnt == win_cnt) state_n = FIN;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The trailing most-negative element pushes the last window's result out of the pool unit.
  assign pool_en  = rd_q | flush_q;
  assign pool_in  = rd_q ? mem_rdata : (flush_q ? MOST_NEG : '0);
  assign res_we   = res_we_q;
  assign res_addr = res_addr_q;
  assign res_data = res_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dim_q      <= '0;
      elem_q     <= '0;
      kx         <= '0;
      ky         <= '0;
      wx         <= '0;
      wy         <= '0;
      win_cnt    <= '0;
      cap_cnt    <= '0;
      rd_q       <= 1'b0;
      flush_q    <= 1'b0;
      res_we_q   <= 1'b0;
      res_data_q <= '0;
      res_addr_q <= '0;
    end else begin
      state    <= state_n;
      rd_q     <= mem_rd;
      flush_q  <= (state == FLUSH) && !stall_w;
      res_we_q <= accept;
      if (accept) res_data_q <= pool_out;

      if (state == IDLE && start) begin
        dim_q      <= map_dim;
        elem_q     <= element;
        kx         <= '0;
        ky         <= '0;
        wx         <= '0;
        wy         <= '0;
        win_cnt    <= '0;
        cap_cnt    <= '0;
        res_addr_q <= '0;
      end else begin
        if (accept) cap_cnt <= cap_cnt + CNT_W'(1);
        if (res_we_q) res_addr_q <= res_addr_q + RES_AW'(1);
        if (step) begin
          if (!last_kx) begin
            kx <= kx + 4'd1;
          end else begin
            kx <= '0;
            if (!last_ky) begin
              ky <= ky + 4'd1;
            end else begin
              ky      <= '0;
              win_cnt <= win_cnt + CNT_W'(1);
              if (wx_fit) begin
                wx <= wx + DIM_W'(elem_q);
              end else begin
                wx <= '0;
                if (wy_fit) wy <= wy + DIM_W'(elem_q);
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: table vectors, hand sequences and random passes checked
// against a window-max reference computed directly from the map contents.
module tb_pool_window_feeder;

  localparam int DATA_W = 21;
  localparam int ADDR_W = 10;
  localparam int RES_AW = 8;
  localparam int DIM_W  = 6;
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  map_dim = '0;
  logic [3:0]        element = '0;
`ifdef POOL_STALL_EN
  logic              stall = 1'b0;
`endif
  logic              busy, done, mem_rd, pool_rst, pool_en, res_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pool_in;
  logic              pool_done;
  logic [DATA_W-1:0] pool_out;
  logic [RES_AW-1:0] res_addr;
  logic [DATA_W-1:0] res_data;

  always #5 clk = ~clk;

  pool_window_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RES_AW(RES_AW), .DIM_W(DIM_W)) dut (
    .clk(clk), .reset(reset), .start(start), .map_dim(map_dim), .element(element),
`ifdef POOL_STALL_EN
    .stall(stall),
`endif
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pool_rst(pool_rst), .pool_en(pool_en), .pool_in(pool_in), .pool_done(pool_done),
    .pool_out(pool_out), .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
  );

  logic signed [DATA_W-1:0] mem [0:1023];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // Max-pool stand-in: reports a window when the first element of the next one arrives.
  int pm_wsize = 1;
  int pm_cnt;
  logic signed [DATA_W-1:0] pm_max;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pool_done <= 1'b0;
      pool_out  <= '0;
      pm_cnt    <= 0;
      pm_max    <= '0;
    end else begin
      pool_done <= 1'b0;
      if (pool_rst) begin
        pm_cnt <= 0;
      end else if (pool_en) begin
        if (pm_cnt == pm_wsize) begin
          pool_done <= 1'b1;
          pool_out  <= pm_max;
          pm_max    <= pool_in;
          pm_cnt    <= 1;
        end else begin
          if (pm_cnt == 0 || $signed(pool_in) > pm_max) pm_max <= pool_in;
          pm_cnt <= pm_cnt + 1;
        end
      end
    end
  end

  typedef struct {
    int     dim;
    int     elem;
    int     mode;
    int     exp_done;
    int     exp_nres;
    longint exp_first;
    longint exp_last;
  } vec_t;

  vec_t   vecs[5];
  int     addr_ref[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int     total = 0;
  int     bad = 0;
  int     exp_addr[$], obs_addr[$];
  longint exp_res[$], obs_res[$];
  int     exp_done, done_k, prst_cnt;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fillMem(input int mode);
    for (int a = 0; a < 1024; a++) begin
      case (mode)
        0: mem[a] = DATA_W'(a);
        1: mem[a] = DATA_W'(-a);
        2: mem[a] = DATA_W'(a - 4);
        3: mem[a] = DATA_W'($urandom);
        default: mem[a] = DATA_W'(-1);
      endcase
    end
    if (mode == 4) mem[9] = DATA_W'(100);
  endtask

  // Reference: enumerate fitting windows, list their addresses, take each window's maximum.
  task automatic buildModel(input int dim, input int elem, input int extra);
    int n, a;
    longint mx, v;
    exp_addr.delete();
    exp_res.delete();
    n = (elem == 0 || elem > dim) ? 0 : dim / elem;
    for (int wy = 0; wy < n; wy++)
      for (int wx = 0; wx < n; wx++) begin
        mx = 0;
        for (int ky = 0; ky < elem; ky++)
          for (int kx = 0; kx < elem; kx++) begin
            a = (wy * elem + ky) * dim + wx * elem + kx;
            exp_addr.push_back(a);
            v = longint'(mem[a]);
            if ((ky == 0 && kx == 0) || v > mx) mx = v;
          end
        exp_res.push_back(mx);
      end
    exp_done = (n == 0) ? 2 : 2 + n * n * elem * elem + 4 + extra;
  endtask

  task automatic applyStimulus(input int dim, input int elem, input int stall_lo,
                               input int stall_hi, input bit noise);
    int k;
    int budget;
    obs_addr.delete();
    obs_res.delete();
    done_k   = 0;
    prst_cnt = 0;
    budget   = exp_done + 30;
    pm_wsize = elem * elem;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    map_dim = DIM_W'(dim);
    element = 4'(elem);
    start   = 1'b1;
    @(posedge clk);
    k = 1;
    #1;
    start = 1'b0;
    while (k <= budget) begin
      @(negedge clk);
      if (mem_rd) obs_addr.push_back(int'(mem_addr));
      if (pool_rst) prst_cnt++;
      if (res_we) begin
        checkOutput("res_addr", res_addr, obs_res.size());
        checkOutput("flush_leak", res_data == MIN_VAL, 0);
        obs_res.push_back(longint'($signed(res_data)));
      end
      if (done) begin
        done_k = k;
        start  = 1'b0;
        break;
      end
      @(posedge clk);
      k++;
      #1;
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        map_dim = DIM_W'($urandom);
        element = 4'($urandom);
      end
`ifdef POOL_STALL_EN
      stall = (k >= stall_lo && k <= stall_hi);
`endif
    end
`ifdef POOL_STALL_EN
    stall = 1'b0;
`endif
    checkOutput("done_seen", done_k != 0, 1);
    checkOutput("done_cycle", done_k, exp_done);
    checkOutput("pool_rst_pulses", prst_cnt, 1);
    checkOutput("read_count", obs_addr.size(), exp_addr.size());
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
      checkOutput("read_addr", obs_addr[i], exp_addr[i]);
    checkOutput("result_count", obs_res.size(), exp_res.size());
    for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++)
      checkOutput("result_value", obs_res[i], exp_res[i]);
  endtask

  task automatic resetMidPass();
    int seen_done;
    fillMem(0);
    pm_wsize = 4;
    @(negedge clk);
    map_dim = DIM_W'(4);
    element = 4'(2);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_outputs",
                {busy, done, mem_rd, pool_rst, pool_en, res_we,
                 |mem_addr, |pool_in, |res_addr, |res_data}, 0);
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || res_we) seen_done = 1;
    end
    checkOutput("midreset_no_done", seen_done, 0);
    reset = 1'b0;
  endtask

  initial begin
    int extra, slo, shi, bad_cols, d, e;
    vecs[0] = '{4, 2, 0, 22, 4, 5, 15};
    vecs[1] = '{5, 2, 1, 22, 4, 0, -12};
    vecs[2] = '{3, 1, 2, 15, 9, -4, 4};
    vecs[3] = '{4, 0, 0, 2, 0, 0, 0};
    vecs[4] = '{4, 7, 0, 2, 0, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs",
                {busy, done, mem_rd, pool_rst, pool_en, res_we,
                 |mem_addr, |pool_in, |res_addr, |res_data}, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      extra = 0;
      slo   = 0;
      shi   = -1;
`ifdef POOL_STALL_EN
      if (i == 0) begin
        extra = 4;
        slo   = 5;
        shi   = 8;
      end
`endif
      fillMem(vecs[i].mode);
      buildModel(vecs[i].dim, vecs[i].elem, extra);
      applyStimulus(vecs[i].dim, vecs[i].elem, slo, shi, 1'b0);
      checkOutput("tbl_done", done_k, vecs[i].exp_done + extra);
      checkOutput("tbl_nres", obs_res.size(), vecs[i].exp_nres);
      if (vecs[i].exp_nres > 0 && obs_res.size() == vecs[i].exp_nres) begin
        checkOutput("tbl_first", obs_res[0], vecs[i].exp_first);
        checkOutput("tbl_last", obs_res[vecs[i].exp_nres-1], vecs[i].exp_last);
      end
      if (i == 0 && obs_addr.size() == 16)
        for (int j = 0; j < 16; j++) checkOutput("tbl_addr", obs_addr[j], addr_ref[j]);
      if (i == 1) begin
        bad_cols = 0;
        foreach (obs_addr[j]) if (obs_addr[j] % 5 == 4 || obs_addr[j] >= 20) bad_cols++;
        checkOutput("edge_reads", bad_cols, 0);
      end
    end

    $display("[TB] back-to-back passes");
    fillMem(0);
    buildModel(4, 2, 0);
    applyStimulus(4, 2, 0, -1, 1'b0);
    fillMem(4);
    buildModel(4, 4, 0);
    applyStimulus(4, 4, 0, -1, 1'b0);
    checkOutput("b2b_nres", obs_res.size(), 1);
    if (obs_res.size() == 1) checkOutput("b2b_value", obs_res[0], 100);

    $display("[TB] reset in mid-pass");
    resetMidPass();
    fillMem(0);
    buildModel(4, 2, 0);
    applyStimulus(4, 2, 0, -1, 1'b0);

    $display("[TB] random passes");
    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(1, 10);
      e = $urandom_range(0, 5);
      fillMem(3);
      buildModel(d, e, 0);
      applyStimulus(d, e, 0, -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
